// File: rtl/soml_pkg.sv
// Shared SOML decoder parameters and the argmin FSM state type.
package soml_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_CAND = 16;
  localparam int unsigned IDX_W    = $clog2(NUM_CAND);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmin_state_t;

endpackage

// File: rtl/min_cmp.sv
// Combinational running-minimum step: folds one metric into the current min/index.
module min_cmp #(
  parameter int unsigned DATA_W = soml_pkg::DATA_W,
  parameter int unsigned IDX_W  = soml_pkg::IDX_W
) (
  input  logic              first_i,
  input  logic [DATA_W-1:0] metric_i,
  input  logic [DATA_W-1:0] run_min_i,
  input  logic [IDX_W-1:0]  cnt_i,
  input  logic [IDX_W-1:0]  run_idx_i,
  output logic [DATA_W-1:0] min_c_o,
  output logic [IDX_W-1:0]  idx_c_o,
  output logic              take_c_o
);

  // Strict less-than keeps the lowest index on ties; first forces the load.
  assign take_c_o = first_i | (metric_i < run_min_i);
  assign min_c_o  = take_c_o ? metric_i : run_min_i;
  assign idx_c_o  = take_c_o ? cnt_i    : run_idx_i;

endmodule

// File: rtl/metric_argmin.sv
// Selects the smallest trace metric (and its arrival index) over a frame of candidates.
module metric_argmin #(
  parameter int unsigned DATA_W   = soml_pkg::DATA_W,
  parameter int unsigned NUM_CAND = soml_pkg::NUM_CAND,
  parameter int unsigned IDX_W    = $clog2(NUM_CAND)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              metric_valid,
  input  logic [DATA_W-1:0] metric,
  output logic [DATA_W-1:0] best_metric,
  output logic [IDX_W-1:0]  best_idx,
  output logic              done,
  output logic              busy,
  output logic              err
);

  import soml_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

  argmin_state_t     state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;
  logic [DATA_W-1:0] run_min_q, run_min_d;
  logic [IDX_W-1:0]  run_idx_q, run_idx_d;
  logic [DATA_W-1:0] best_metric_q, best_metric_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] cmp_min_c;
  logic [IDX_W-1:0]  cmp_idx_c;
  logic              cmp_take_c;

  min_cmp #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_min_cmp (
    .first_i   (first_q),
    .metric_i  (metric),
    .run_min_i (run_min_q),
    .cnt_i     (cnt_q),
    .run_idx_i (run_idx_q),
    .min_c_o   (cmp_min_c),
    .idx_c_o   (cmp_idx_c),
    .take_c_o  (cmp_take_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath/output next values.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    first_d       = first_q;
    run_min_d     = run_min_q;
    run_idx_d     = run_idx_q;
    best_metric_d = best_metric_q;
    best_idx_d    = best_idx_q;
    err_d         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          cnt_d     = '0;
          first_d   = 1'b1;
          run_min_d = '1;
        end else if (metric_valid) begin
          err_d = 1'b1;
        end
      end

      SCAN: begin
        // A start here restarts the frame and drops any coincident metric.
        if (start) begin
          cnt_d     = '0;
          first_d   = 1'b1;
          run_min_d = '1;
        end else if (metric_valid) begin
          run_min_d = cmp_min_c;
          run_idx_d = cmp_idx_c;
          if (cmp_take_c) begin
            first_d = 1'b0;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d       = DONE;
            best_metric_d = cmp_min_c;
            best_idx_d    = cmp_idx_c;
          end
        end
      end

      DONE: begin
        if (start) begin
          state_d   = SCAN;
          cnt_d     = '0;
          first_d   = 1'b1;
          run_min_d = '1;
        end else begin
          state_d = IDLE;
          err_d   = metric_valid;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SCAN);
    done_d = (state_d == DONE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      first_q       <= 1'b0;
      run_min_q     <= '1;
      run_idx_q     <= '0;
      best_metric_q <= '0;
      best_idx_q    <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      first_q       <= first_d;
      run_min_q     <= run_min_d;
      run_idx_q     <= run_idx_d;
      best_metric_q <= best_metric_d;
      best_idx_q    <= best_idx_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign best_metric = best_metric_q;
  assign best_idx    = best_idx_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: doc/metric_argmin.md
# metric_argmin

Collects the per-candidate trace metrics produced by the SOML decoder's trace-calculation stage and selects the candidate with the smallest metric. It consumes the 16-bit `out`/`finish` pair of that stage, one metric per `finish` pulse, over a frame of `NUM_CAND` candidates. At frame end it outputs the winning index and metric with a one-cycle `done` strobe for the symbol-decision stage downstream.

## Interface
- `DATA_W`, 16: metric width; matches the trace stage output.
- `NUM_CAND`, 16: candidates per frame, ≥2.
- `IDX_W`, `$clog2(NUM_CAND)`: candidate index width.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; deassertion is synchronised to `clk` externally.
- `start`  in  1  one-cycle strobe; opens a new frame and aborts any frame in progress.
- `metric_valid`  in  1  one-cycle strobe; driven by the trace stage's `finish`.
- `metric`  in  DATA_W  unsigned metric; sampled only when `metric_valid`=1.
- `best_metric`  out  DATA_W  minimum metric of the last completed frame.
- `best_idx`  out  IDX_W  index (0-based arrival order) of that minimum.
- `done`  out  1  one-cycle pulse; frame complete, `best_*` valid.
- `busy`  out  1  high while a frame is collecting.
- `err`  out  1  one-cycle pulse; metric arrived outside a frame and was dropped.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: `busy`=0. `start` → SCAN; clears the candidate counter `cnt`, sets the `first` flag, and loads the running minimum `run_min` with all-ones. `metric_valid` without `start` → `err` pulse, metric dropped, stay IDLE.
- SCAN: `busy`=1. On each `metric_valid`:
  - If `first`=1 or `metric` < `run_min` (strict unsigned compare), load `run_min`←`metric`, `run_idx`←`cnt`, and clear `first`.
  - Increment `cnt`.
  - If `cnt`==NUM_CAND-1 when the metric is accepted → DONE.
- Tie rule: strict less-than, so on equal metrics the lowest index wins. Because `first` forces the load, an all-ones first metric still yields index 0.
- DONE: lasts one cycle. `done`=1. `best_metric`←final minimum and `best_idx`←final index, both registered. Then → IDLE.
- The final compare folds the last metric in before the outputs are registered, so `best_*` includes candidate NUM_CAND-1.
- `best_metric` and `best_idx` hold their values until the next DONE. A new `start` does not clear them.
- `start` in SCAN: the frame is restarted and `cnt`, `first` and `run_min` are reinitialised. No `done`; `best_*` are unchanged.
- `start` in DONE: `done` still pulses this cycle, then the block goes to SCAN with a fresh frame instead of IDLE.
- `start` and `metric_valid` in the same cycle: `start` wins and the metric is dropped. `err` is not raised.
- `metric_valid` in DONE: dropped, and `err` pulses.
- Reset (any time, mid-frame included): state←IDLE, `cnt`←0, `run_min`←all-ones, `run_idx`←0, `first`←0. Outputs reset to `best_metric`=0, `best_idx`=0, `done`=0, `busy`=0, `err`=0.

## Timing
- `busy` rises the cycle after `start`, so a metric is accepted no earlier than the cycle after `start`.
- Back-to-back `metric_valid` (every cycle) is supported, giving full throughput.
- Latency: last metric sampled at edge k → `done`=1 and `best_*` valid during cycle k+1. `busy`=0 from cycle k+1.
- `err` pulses in the cycle after the offending `metric_valid`.
- All outputs are registered, with no combinational input-to-output path.

## Structure
- Shared package `soml_pkg`: `DATA_W`, `NUM_CAND`, `IDX_W`, and a state enum `argmin_state_t` {IDLE, SCAN, DONE}. The trace stage uses the same `DATA_W`.
- One natural sub-module, `min_cmp`, which is combinational: it takes `first`, `metric`, `run_min`, `cnt` and `run_idx`, and returns the next min, the next index, and a take flag.
- The FSM, counter and output registers stay in `metric_argmin`.

## Test plan
- Reset then idle: all outputs 0. Send `metric_valid` with `metric`=0x0005 and no `start` → `err` pulses once, `done` stays 0.
- Monotonic frame, NUM_CAND=16: metrics 16..1 one per cycle → `done` one cycle after the last, `best_idx`=15, `best_metric`=1.
- Ties and all-ones: metrics all 0xFFFF except idx 3 and idx 9 = 0x0010 → `best_idx`=3. A frame of all 0xFFFF → `best_idx`=0, `best_metric`=0xFFFF.
- Restart mid-frame: send 7 metrics (min 0x0001), then `start` together with a `metric_valid`, then 16 metrics with min 0x0040 at idx 5 → exactly one `done`, `best_idx`=5, `best_metric`=0x0040, no `err`.
- Gapped input: 16 metrics spaced by a random gap of 0–8 cycles (mimicking the trace `finish` cadence) → result matches the reference model, `busy` stays high throughout.
- Async reset asserted mid-frame between clock edges → outputs 0 immediately. After release and a new `start` plus a full frame → correct result, no stale state.
